// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM: walks the register list lowest index
// first, issuing one memory request per set bit, then optionally writes back
// the updated base register.
module ldm_stm_sequencer #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  up,
    input  logic                  pre,
    input  logic                  writeback,
    input  logic [NUM_REGS-1:0]   reg_list,
    input  logic [ADDR_WIDTH-1:0] base_reg,
    input  logic [WORD_SIZE-1:0]  base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_rm,
    input  logic [WORD_SIZE-1:0]  rm_data,
    output logic [ADDR_WIDTH-1:0] write_rd,
    output logic                  rd_we,
    output logic [WORD_SIZE-1:0]  rd_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

    localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(4);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Command context captured at start. up/pre are folded into the start
    // address and the writeback value, so they need no register of their own.
    logic                  is_load_q;
    logic                  wb_en_q;
    logic [ADDR_WIDTH-1:0] base_reg_q;
    logic [NUM_REGS-1:0]   list_q;
    logic [WORD_SIZE-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  wb_val_q;

    logic [WORD_SIZE-1:0]  n_regs;
    logic [WORD_SIZE-1:0]  four_n;
    logic [WORD_SIZE-1:0]  start_addr;
    logic [WORD_SIZE-1:0]  wb_val;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [NUM_REGS-1:0]   list_rest;

    // Popcount of the incoming list and the derived start address / final base.
    always_comb begin
        n_regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            n_regs = n_regs + WORD_SIZE'(reg_list[i]);
        end
        four_n = n_regs << 2;
        case ({up, pre})
            2'b10:   start_addr = base_addr;
            2'b11:   start_addr = base_addr + STEP;
            2'b00:   start_addr = base_addr - four_n + STEP;
            default: start_addr = base_addr - four_n;
        endcase
        wb_val = up ? (base_addr + four_n) : (base_addr - four_n);
        wb_en  = writeback & ~(is_load & reg_list[base_reg]);
    end

    // Current register is the lowest set bit still pending in the list.
    always_comb begin
        cur_idx = '0;
        for (int unsigned i = NUM_REGS; i > 0; i--) begin
            if (list_q[i-1]) begin
                cur_idx = ADDR_WIDTH'(i - 1);
            end
        end
        list_rest = list_q & (list_q - NUM_REGS'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and transfer walker: clear one list bit and step the
    // address by one word on every acknowledged transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_load_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            base_reg_q <= '0;
            list_q     <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
        end else if (state_q == IDLE && start) begin
            is_load_q  <= is_load;
            wb_en_q    <= wb_en;
            base_reg_q <= base_reg;
            list_q     <= reg_list;
            addr_q     <= start_addr;
            wb_val_q   <= wb_val;
        end else if (state_q == XFER && mem_ack) begin
            list_q <= list_rest;
            addr_q <= addr_q + STEP;
        end
    end

    // Next-state and output decode; every output is gated by state so that
    // reset forces them all low without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        read_rm   = '0;
        write_rd  = '0;
        rd_we     = 1'b0;
        rd_in     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (reg_list == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = ~is_load_q;
                mem_addr = addr_q;
                if (is_load_q) begin
                    if (mem_ack) begin
                        rd_we    = 1'b1;
                        write_rd = cur_idx;
                        rd_in    = mem_rdata;
                    end
                end else begin
                    read_rm   = cur_idx;
                    mem_wdata = rm_data;
                end
                if (mem_ack && list_rest == '0) begin
                    state_d = wb_en_q ? WB : DONE;
                end
            end
            WB: begin
                rd_we    = 1'b1;
                write_rd = base_reg_q;
                rd_in    = wb_val_q;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a list-level reference model queues
// expected memory transfers, register writes and done pulses; a negedge
// monitor pops and compares them as the DUT produces them.
module tb_ldm_stm_sequencer;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          is_load = 1'b0, up = 1'b0, pre = 1'b0, writeback = 1'b0;
    logic [NR-1:0] reg_list = '0;
    logic [AW-1:0] base_reg = '0;
    logic [W-1:0]  base_addr = '0;
    logic          busy, done;
    logic [AW-1:0] read_rm, write_rd;
    logic          rd_we;
    logic [W-1:0]  rd_in, rm_data;
    logic          mem_req, mem_we;
    logic          mem_ack = 1'b0;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_mode = 0;

    typedef struct {
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
    } rw_exp_t;

    mem_exp_t mem_q[$];
    rw_exp_t  rw_q[$];
    int       done_q[$];
    logic [W-1:0] rf [NR];

    ldm_stm_sequencer #(.WORD_SIZE(W), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .up(up),
        .pre(pre), .writeback(writeback), .reg_list(reg_list), .base_reg(base_reg),
        .base_addr(base_addr), .busy(busy), .done(done), .read_rm(read_rm),
        .rm_data(rm_data), .write_rd(write_rd), .rd_we(rd_we), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign rm_data   = rf[read_rm];
    assign mem_rdata = mem_ack ? mem_val(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: compares whatever the DUT presents each cycle.
    initial begin
        mem_exp_t m;
        rw_exp_t  r;
        int       d;
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_req_unexpected", W'(mem_req), 32'd0);
                    end else begin
                        m = mem_q[0];
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_we", W'(mem_we), W'(m.we));
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                        if (mem_ack) void'(mem_q.pop_front());
                    end
                end
                if (rd_we) begin
                    if (mem_req && !mem_ack) chk("rd_we_without_ack", W'(rd_we), 32'd0);
                    if (rw_q.size() == 0) begin
                        chk("rd_we_unexpected", W'(rd_we), 32'd0);
                    end else begin
                        r = rw_q.pop_front();
                        chk("write_rd", W'(write_rd), W'(r.idx));
                        chk("rd_in", rd_in, r.data);
                    end
                    rf[write_rd] = rd_in;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", W'(done), 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        if (d >= 0) chk("done_cycle", W'(cyc), W'(d));
                    end
                end
            end
        end
    end

    // Memory responder: ack pattern per mode, set just after each posedge.
    initial begin
        int nacked = 0;
        int waitc = 0;
        forever begin
            @(posedge clk);
            if (!busy) begin
                nacked = 0;
                waitc  = 0;
            end else if (mem_req && mem_ack) begin
                nacked++;
            end
            #1;
            case (ack_mode)
                0: mem_ack = 1'b1;
                1: mem_ack = ($urandom_range(0, 2) != 0);
                default: begin
                    if (mem_req && nacked == 1 && waitc < 3) begin
                        mem_ack = 1'b0;
                        waitc++;
                    end else begin
                        mem_ack = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic scramble();
        is_load   = 1'($urandom);
        up        = 1'($urandom);
        pre       = 1'($urandom);
        writeback = 1'($urandom);
        reg_list  = NR'($urandom);
        base_reg  = AW'($urandom);
        base_addr = $urandom;
    endtask

    // Reference model: expected traffic from the list rules, then start pulse.
    task automatic issue(input logic ld, input logic u, input logic p, input logic wb,
                         input logic [NR-1:0] lst, input logic [AW-1:0] br,
                         input logic [W-1:0] base);
        int           n;
        int           lat;
        logic         do_wb;
        logic [W-1:0] a;
        mem_exp_t     m;
        rw_exp_t      r;
        n = $countones(lst);
        case ({u, p})
            2'b10:   a = base;
            2'b11:   a = base + 32'd4;
            2'b00:   a = base - W'(4 * n) + 32'd4;
            default: a = base - W'(4 * n);
        endcase
        for (int i = 0; i < NR; i++) begin
            if (lst[i]) begin
                m.addr  = a;
                m.we    = !ld;
                m.wdata = ld ? 32'd0 : rf[i];
                mem_q.push_back(m);
                if (ld) begin
                    r.idx  = AW'(i);
                    r.data = mem_val(a);
                    rw_q.push_back(r);
                end
                a = a + 32'd4;
            end
        end
        do_wb = wb && (n > 0) && !(ld && lst[br]);
        if (do_wb) begin
            r.idx  = br;
            r.data = u ? base + W'(4 * n) : base - W'(4 * n);
            rw_q.push_back(r);
        end
        lat = (n == 0) ? 1 : n + 1 + int'(do_wb);
        done_q.push_back(ack_mode == 0 ? cyc + lat : -1);
        chk("idle_before_start", W'(busy), 32'd0);
        is_load = ld; up = u; pre = p; writeback = wb;
        reg_list = lst; base_reg = br; base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", W'(busy), 32'd1);
        scramble();
    endtask

    // Wait for the command to drain; optionally hammer start while busy.
    task automatic finish_cmd(input bit poke);
        int k = 0;
        while (busy && k < 300) begin
            if (poke) begin
                scramble();
                start = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (busy) chk("busy_timeout", W'(busy), 32'd0);
        chk("mem_q_drained", W'(mem_q.size()), 32'd0);
        chk("rw_q_drained", W'(rw_q.size()), 32'd0);
        chk("done_q_drained", W'(done_q.size()), 32'd0);
        mem_q.delete();
        rw_q.delete();
        done_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, W'(busy), 32'd0);
        chk({tag, "_done"}, W'(done), 32'd0);
        chk({tag, "_mem_req"}, W'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, W'(mem_we), 32'd0);
        chk({tag, "_rd_we"}, W'(rd_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rd_in"}, rd_in, 32'd0);
        chk({tag, "_read_rm"}, W'(read_rm), 32'd0);
        chk({tag, "_write_rd"}, W'(write_rd), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] lst;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // LDM increment-after, writeback r0.
        ack_mode = 0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h000E, 4'd0, 32'h0000_0100);
        finish_cmd(1'b0);
        chk("ldm_r1", rf[1], mem_val(32'h100));
        chk("ldm_r2", rf[2], mem_val(32'h104));
        chk("ldm_r3", rf[3], mem_val(32'h108));
        chk("ldm_r0_wb", rf[0], 32'h0000_010C);

        // STM decrement-before, writeback r13.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 4'd13, 32'h0000_0200);
        finish_cmd(1'b0);
        chk("stm_r13_wb", rf[13], 32'h0000_01F8);

        // LDM with base in list: loaded value wins, no WB cycle.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0011, 4'd4, 32'h0000_0400);
        finish_cmd(1'b0);
        chk("ldm_base_in_list", rf[4], mem_val(32'h404));

        // STM with base in list stores the original base value.
        issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 4'd5, 32'h0000_0800);
        finish_cmd(1'b0);

        // Three-cycle ack stall on the second transfer, load and store.
        ack_mode = 2;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h00F0, 4'd1, 32'h0000_1000);
        finish_cmd(1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h0F00, 4'd2, 32'h0000_2000);
        finish_cmd(1'b0);

        // Empty list with writeback, start pokes during busy and DONE.
        ack_mode = 0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd3, 32'h0000_0500);
        finish_cmd(1'b1);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h0C03, 4'd7, 32'h0000_0600);
        finish_cmd(1'b1);

        // Reset in the middle of the second of four transfers.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h0F00, 4'd2, 32'h0000_3000);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        mem_q.delete();
        rw_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        check_zero("held_reset");
        reset_n = 1'b1;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 16'h0F00, 4'd2, 32'h0000_3000);
        finish_cmd(1'b0);
        chk("after_reset_wb", rf[2], 32'h0000_2FF0);

        // Randomized commands, including address wrap and random ack stalls.
        for (int t = 0; t < 40; t++) begin
            ack_mode = $urandom_range(0, 1);
            lst = ($urandom_range(0, 7) == 0) ? '0 : NR'($urandom);
            issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  lst, AW'($urandom), $urandom);
            finish_cmd(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
